// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the I/D memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_e;

   typedef enum logic [1:0] {FE_NONE, FE_ACCESS_FAULT} err_type_e;

   typedef struct packed {
      logic        valid;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      mem_size_e   size;
   } cache_req_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
      logic        error;
      err_type_e   errty;
   } cache_resp_t;

   typedef enum logic {ARB_I, ARB_D} arb_owner_e;

   typedef enum logic [1:0] {IDLE, WAIT_READY, WAIT_RESP, LOCAL_ERR} arb_state_e;

   // Only the two low address bits matter: halfwords need bit 0 clear, words need both clear.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input mem_size_e size);
      case (size)
         SIZE_H:  return addr_lo[0];
         SIZE_W:  return |addr_lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache request/response port bundle
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   cache_req_t  req;
   logic        ready;
   cache_resp_t resp;

   // Requester side: issues requests, sees ready and responses.
   modport master (output req, input ready, input resp);
   // Responder side: accepts requests, returns ready and responses.
   modport slave  (input req, output ready, output resp);

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one cache port between fetch and data requesters
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter bit DATA_FIRST       = 1'b1,
   parameter bit ADDR_ALIGN_CHECK = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   mem_port_arbiter_if.slave         ibus,
   mem_port_arbiter_if.slave         dbus,
   mem_port_arbiter_if.master        mbus,
   input  logic                      i_kill,
   output logic                      busy,
   output logic                      grant_d
);

   // The requester that lost the imaginary "previous" round wins the first contention.
   localparam arb_owner_e LAST_RST = DATA_FIRST ? ARB_I : ARB_D;

   arb_state_e state_q, state_d;
   arb_owner_e owner_q, owner_d;
   arb_owner_e last_q, last_d;
   logic       drop_resp_q, drop_resp_d;

   logic       i_req_v;
   logic       d_req_v;
   logic       sel_valid;
   cache_req_t sel_req;
   arb_owner_e owner_win;

   // State, grant owner, round-robin pointer and killed-response flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= ARB_I;
         last_q      <= LAST_RST;
         drop_resp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         drop_resp_q <= drop_resp_d;
      end
   end

   // Arbitration, next state and the request/response steering mux.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      drop_resp_d = drop_resp_q;
      owner_win   = ARB_I;

      mbus.req    = '0;
      ibus.ready  = 1'b0;
      dbus.ready  = 1'b0;
      ibus.resp   = '0;
      dbus.resp   = '0;

      // A fetch being redirected is treated as not requesting at all.
      i_req_v   = ibus.req.valid & ~i_kill;
      d_req_v   = dbus.req.valid;
      sel_req   = (owner_q == ARB_D) ? dbus.req : ibus.req;
      sel_valid = (owner_q == ARB_D) ? d_req_v : i_req_v;

      case (state_q)
         IDLE: begin
            if (i_req_v || d_req_v) begin
               if (i_req_v && d_req_v)
                  owner_win = (last_q == ARB_I) ? ARB_D : ARB_I;
               else
                  owner_win = d_req_v ? ARB_D : ARB_I;
               owner_d = owner_win;
               last_d  = owner_win;
               if (ADDR_ALIGN_CHECK && owner_win == ARB_D &&
                   is_misaligned(dbus.req.addr[1:0], dbus.req.size))
                  state_d = LOCAL_ERR;
               else
                  state_d = WAIT_READY;
            end
         end

         WAIT_READY: begin
            mbus.req       = sel_req;
            mbus.req.valid = sel_valid;
            if (owner_q == ARB_D)
               dbus.ready = mbus.ready & sel_valid;
            else
               ibus.ready = mbus.ready & sel_valid;
            if (!sel_valid)
               state_d = IDLE;
            else if (mbus.ready)
               state_d = WAIT_RESP;
         end

         WAIT_RESP: begin
            if (owner_q == ARB_D) begin
               dbus.resp = mbus.resp;
            end else begin
               ibus.resp       = mbus.resp;
               ibus.resp.valid = mbus.resp.valid & ~drop_resp_q & ~i_kill;
               if (mbus.resp.valid)
                  drop_resp_d = 1'b0;
               else if (i_kill)
                  drop_resp_d = 1'b1;
            end
            if (mbus.resp.valid)
               state_d = IDLE;
         end

         LOCAL_ERR: begin
            // Misaligned data access is absorbed here and never reaches the cache.
            dbus.ready       = dbus.req.valid;
            dbus.resp.valid  = dbus.req.valid;
            dbus.resp.error  = 1'b1;
            dbus.resp.errty  = FE_ACCESS_FAULT;
            state_d          = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign grant_d = (owner_q == ARB_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      err_type_e   errty;
      bit          chk_data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic i_kill = 1'b0;
   logic busy;
   logic grant_d;

   mem_port_arbiter_if ibus ();
   mem_port_arbiter_if dbus ();
   mem_port_arbiter_if mbus ();

   mem_port_arbiter #(.DATA_FIRST(1'b1), .ADDR_ALIGN_CHECK(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .ibus    (ibus),
      .dbus    (dbus),
      .mbus    (mbus),
      .i_kill  (i_kill),
      .busy    (busy),
      .grant_d (grant_d)
   );

   always #5 clk = ~clk;

   exp_t        exp_i_q[$];
   exp_t        exp_d_q[$];
   cache_req_t  pend_i_q[$];
   cache_req_t  pend_d_q[$];
   logic [31:0] acc_log[$];

   int          checks = 0;
   int          failures = 0;
   logic        mready_en;
   int          mem_lat;
   logic        m_err;
   int          resp_cnt;
   logic [31:0] mem_addr;
   logic        mem_err_l;
   bit          d_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ~a;
   endfunction

   task automatic cmp_resp(input string tag, input cache_resp_t r, input exp_t e);
      if (e.chk_data) chk({tag, "_rdata"}, r.rdata, e.rdata);
      chk({tag, "_error"}, r.error, e.error);
      chk({tag, "_errty"}, r.errty, e.errty);
   endtask

   // One clock: observe at negedge, then update requesters and memory model just after posedge.
   task automatic cycle();
      logic        i_acc, d_acc, m_acc;
      logic [31:0] m_addr;
      exp_t        e;
      @(negedge clk);
      i_acc  = ibus.req.valid & ibus.ready;
      d_acc  = dbus.req.valid & dbus.ready;
      m_acc  = mbus.req.valid & mbus.ready;
      m_addr = mbus.req.addr;
      if (m_acc) acc_log.push_back(m_addr);
      chk("resp_exclusive", ibus.resp.valid & dbus.resp.valid, 1'b0);
      if (ibus.resp.valid) begin
         chk("iresp_expected", exp_i_q.size() != 0, 1'b1);
         if (exp_i_q.size() != 0) begin
            e = exp_i_q.pop_front();
            cmp_resp("iresp", ibus.resp, e);
         end
      end
      if (dbus.resp.valid) begin
         d_seen = 1'b1;
         chk("dresp_expected", exp_d_q.size() != 0, 1'b1);
         if (exp_d_q.size() != 0) begin
            e = exp_d_q.pop_front();
            cmp_resp("dresp", dbus.resp, e);
         end
      end
      @(posedge clk);
      #1;
      if (i_acc) begin
         if (pend_i_q.size() != 0) ibus.req = pend_i_q.pop_front();
         else ibus.req.valid = 1'b0;
      end
      if (d_acc) begin
         if (pend_d_q.size() != 0) dbus.req = pend_d_q.pop_front();
         else dbus.req.valid = 1'b0;
      end
      mbus.resp.valid = 1'b0;
      if (m_acc) begin
         resp_cnt  = mem_lat;
         mem_addr  = m_addr;
         mem_err_l = m_err;
      end
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            mbus.resp.valid = 1'b1;
            mbus.resp.rdata = mem_data(mem_addr);
            mbus.resp.error = mem_err_l;
            mbus.resp.errty = mem_err_l ? FE_ACCESS_FAULT : FE_NONE;
         end
      end
      mbus.ready = mready_en;
   endtask

   task automatic push(input arb_owner_e who, input logic [31:0] addr, input logic wen,
                       input mem_size_e size, input bit want_resp, input logic [31:0] rdata,
                       input logic err, input bit chk_data);
      cache_req_t r;
      exp_t       e;
      r.valid = 1'b1;
      r.wen   = wen;
      r.addr  = addr;
      r.wdata = addr ^ 32'h5555_5555;
      r.wmask = wen ? 4'hF : 4'h0;
      r.size  = size;
      e.rdata = rdata;
      e.error = err;
      e.errty = err ? FE_ACCESS_FAULT : FE_NONE;
      e.chk_data = chk_data;
      if (who == ARB_I) begin
         if (want_resp) exp_i_q.push_back(e);
         if (!ibus.req.valid) ibus.req = r;
         else pend_i_q.push_back(r);
      end else begin
         if (want_resp) exp_d_q.push_back(e);
         if (!dbus.req.valid) dbus.req = r;
         else pend_d_q.push_back(r);
      end
   endtask

   function automatic bit all_idle();
      return exp_i_q.size() == 0 && exp_d_q.size() == 0 && pend_i_q.size() == 0 &&
             pend_d_q.size() == 0 && !ibus.req.valid && !dbus.req.valid &&
             resp_cnt == 0 && !mbus.resp.valid && !busy;
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 100 && !all_idle(); k++) cycle();
      chk({tag, "_drain"}, all_idle(), 1'b1);
   endtask

   initial begin
      logic [31:0] order[4];
      ibus.req   = '0;
      dbus.req   = '0;
      mbus.resp  = '0;
      mready_en  = 1'b1;
      mbus.ready = 1'b1;
      mem_lat    = 1;
      m_err      = 1'b0;
      resp_cnt   = 0;
      mem_addr   = '0;
      mem_err_l  = 1'b0;
      d_seen     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mreq_valid", mbus.req.valid, 1'b0);
      chk("rst_ireq_ready", ibus.ready, 1'b0);
      chk("rst_dreq_ready", dbus.ready, 1'b0);
      chk("rst_iresp_valid", ibus.resp.valid, 1'b0);
      chk("rst_dresp_valid", dbus.resp.valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_d", grant_d, 1'b0);
      reset = 1'b0;

      // Contention from reset: D first, then strict alternation
      acc_log.delete();
      push(ARB_D, 32'h200, 1'b0, SIZE_W, 1'b1, ~32'h200, 1'b0, 1'b1);
      push(ARB_I, 32'h300, 1'b0, SIZE_W, 1'b1, ~32'h300, 1'b0, 1'b1);
      push(ARB_D, 32'h204, 1'b0, SIZE_W, 1'b1, ~32'h204, 1'b0, 1'b1);
      push(ARB_I, 32'h304, 1'b0, SIZE_W, 1'b1, ~32'h304, 1'b0, 1'b1);
      drain("contend");
      order = '{32'h200, 32'h300, 32'h204, 32'h304};
      chk("contend_count", acc_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("contend_order%0d", i), acc_log[i], order[i]);
      chk("contend_grant_d", grant_d, 1'b0);

      // Single D load
      acc_log.delete();
      mem_lat = 2;
      d_seen  = 1'b0;
      push(ARB_D, 32'h100, 1'b0, SIZE_W, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      for (int k = 0; k < 20 && !d_seen; k++) cycle();
      chk("load_seen", d_seen, 1'b1);
      chk("load_busy_after", busy, 1'b0);
      chk("load_grant_d", grant_d, 1'b1);
      drain("load");
      chk("load_addr", acc_log[0], 32'h100);

      // Kill while I waits for its response
      acc_log.delete();
      mem_lat = 4;
      push(ARB_I, 32'h400, 1'b0, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle();
      cycle();
      chk("kill_busy", busy, 1'b1);
      i_kill = 1'b1;
      cycle();
      i_kill = 1'b0;
      push(ARB_I, 32'h500, 1'b0, SIZE_W, 1'b1, ~32'h500, 1'b0, 1'b1);
      drain("kill");
      chk("kill_count", acc_log.size(), 2);
      chk("kill_next", acc_log[1], 32'h500);

      // Kill in the same cycle as the response
      mem_lat = 3;
      push(ARB_I, 32'h440, 1'b0, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (4) cycle();
      chk("kill_same_resp", mbus.resp.valid, 1'b1);
      i_kill = 1'b1;
      cycle();
      i_kill = 1'b0;
      drain("kill_same");

      // D withdraws its request while stalled
      acc_log.delete();
      mem_lat    = 1;
      mready_en  = 1'b0;
      mbus.ready = 1'b0;
      push(ARB_D, 32'h600, 1'b0, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0);
      push(ARB_I, 32'h700, 1'b0, SIZE_W, 1'b1, ~32'h700, 1'b0, 1'b1);
      repeat (6) cycle();
      chk("wd_mreq_valid", mbus.req.valid, 1'b1);
      chk("wd_mreq_addr", mbus.req.addr, 32'h600);
      chk("wd_ireq_ready", ibus.ready, 1'b0);
      dbus.req.valid = 1'b0;
      #1;
      chk("wd_mreq_drop", mbus.req.valid, 1'b0);
      mready_en  = 1'b1;
      mbus.ready = 1'b1;
      drain("withdraw");
      chk("wd_count", acc_log.size(), 1);
      chk("wd_served", acc_log[0], 32'h700);

      // Downstream error passthrough and local alignment errors
      acc_log.delete();
      m_err = 1'b1;
      push(ARB_D, 32'h800, 1'b1, SIZE_W, 1'b1, ~32'h800, 1'b1, 1'b1);
      drain("err_pass");
      m_err = 1'b0;
      push(ARB_D, 32'h102, 1'b0, SIZE_W, 1'b1, 32'h0, 1'b1, 1'b0);
      drain("err_local");
      chk("err_local_count", acc_log.size(), 1);
      push(ARB_D, 32'h106, 1'b0, SIZE_H, 1'b1, ~32'h106, 1'b0, 1'b1);
      push(ARB_D, 32'h105, 1'b0, SIZE_H, 1'b1, 32'h0, 1'b1, 1'b0);
      push(ARB_D, 32'h103, 1'b0, SIZE_B, 1'b1, ~32'h103, 1'b0, 1'b1);
      drain("align");
      chk("align_count", acc_log.size(), 3);
      chk("align_half", acc_log[1], 32'h106);
      chk("align_byte", acc_log[2], 32'h103);

      // Asynchronous reset while waiting for a response
      mem_lat = 5;
      push(ARB_D, 32'h900, 1'b0, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle();
      cycle();
      chk("ar_busy_before", busy, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy", busy, 1'b0);
      chk("ar_mreq_valid", mbus.req.valid, 1'b0);
      chk("ar_dreq_ready", dbus.ready, 1'b0);
      chk("ar_dresp_valid", dbus.resp.valid, 1'b0);
      chk("ar_grant_d", grant_d, 1'b0);
      resp_cnt = 0;
      mbus.resp.valid = 1'b0;
      pend_i_q.delete();
      pend_d_q.delete();
      ibus.req.valid = 1'b0;
      dbus.req.valid = 1'b0;
      #4;
      reset = 1'b0;
      @(posedge clk);
      #1;
      cycle();
      chk("ar_idle_after", busy, 1'b0);
      acc_log.delete();
      mem_lat = 1;
      push(ARB_I, 32'hA00, 1'b0, SIZE_W, 1'b1, ~32'hA00, 1'b0, 1'b1);
      drain("ar_resume");
      chk("ar_resume_addr", acc_log[0], 32'hA00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream cache/memory port (CacheReq/CacheResp) between the instruction-fetch requester (I) and the MemoryStage data requester (D).
- Sits between the fetch and MemoryStage front ends and the single cache/memory unit.
- One outstanding transaction at a time; round-robin arbitration on contention.
- Routes each response, including error/errty, back to the requester that issued it.

Parameters:
- DATA_FIRST, 1: on the first contention after reset, D wins (last_grant resets to I); 0 makes I win first.
- ADDR_ALIGN_CHECK, 0: when 1, a D request whose address is misaligned for its wmask size is answered locally with error=1, errty=FE_ACCESS_FAULT, and is not forwarded.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- ireq  inout  CacheReq  fetch request: valid/wen/addr/wdata/wmask in; ready out.
- iresp  inout  CacheResp  fetch response: valid/rdata/error/errty out.
- i_kill  input  1  fetch redirect; discard any in-flight I transaction.
- dreq  inout  CacheReq  MemoryStage request: fields in; ready out.
- dresp  inout  CacheResp  MemoryStage response out.
- mreq  inout  CacheReq  downstream request: fields out; ready in.
- mresp  inout  CacheResp  downstream response in.
- busy  output  1  state != IDLE.
- grant_d  output  1  current or last grant owner is D (debug/perf).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, last_grant=I (DATA_FIRST=1) or D (DATA_FIRST=0), drop_resp=0.
  - mreq.valid, ireq.ready, dreq.ready, iresp.valid, dresp.valid, busy, grant_d all 0.
  - Reset mid-transaction abandons it; the downstream unit shares the same reset.
- States: IDLE, WAIT_READY, WAIT_RESP, LOCAL_ERR (LOCAL_ERR used only when ADDR_ALIGN_CHECK=1).
- IDLE:
  - Sample ireq.valid and dreq.valid.
  - Only one valid: grant it.
  - Both valid: grant the one that is not last_grant.
  - A valid I request while i_kill=1 is ignored.
  - On a grant: register grant, update last_grant, go to WAIT_READY. Nothing is forwarded in IDLE (1-cycle arbitration latency).
- WAIT_READY:
  - mreq carries the granted requester's fields combinationally; mreq.valid = granted.valid.
  - The granted requester's ready = mreq.ready; the other requester's ready = 0.
  - mreq.valid & mreq.ready: go to WAIT_RESP.
  - Granted valid drops (MemoryStage trap invalidation, or i_kill for I): return to IDLE with no transaction issued.
  - Requesters must hold their fields stable until accepted.
- WAIT_RESP:
  - mreq.valid=0.
  - mresp fields are routed to the granted requester's resp; the other requester's resp.valid=0.
  - mresp.valid: go to IDLE.
  - Minimum accepted-to-accepted spacing is IDLE + WAIT_READY + WAIT_RESP = 3 cycles when ready and response are immediate.
- i_kill while I is in WAIT_RESP:
  - Set drop_resp.
  - The response is still consumed from mresp, but iresp.valid is forced to 0.
  - drop_resp clears on mresp.valid.
  - i_kill asserted in the same cycle as mresp.valid also suppresses that response.
- i_kill has no effect on D transactions.
- LOCAL_ERR (ADDR_ALIGN_CHECK=1, D misaligned at grant):
  - Not forwarded downstream.
  - One cycle: dreq.ready=1, then dresp.valid=1, error=1, errty=FE_ACCESS_FAULT; then IDLE.
  - Alignment rule: SIZE_H needs addr[0]=0; SIZE_W needs addr[1:0]=0.
- Response pulses: resp.valid is a single-cycle pulse per transaction; it is never asserted to both requesters in the same cycle.
- A new request in the same cycle as mresp.valid is arbitered in the following IDLE cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate I/D.
- AMO read-then-write from MemoryStage is two separate D transactions. An interleaved I read between them is permitted, since only one hart exists.

Decomposition:
- Add to pkg_util (or a shared cache package):
  - enum ArbOwner {ARB_I, ARB_D}
  - enum ArbState {IDLE, WAIT_READY, WAIT_RESP, LOCAL_ERR}
  - function is_misaligned(addr, MemSize)
- CacheReq/CacheResp and FE_ACCESS_FAULT stay where they are.
- No sub-module: the request/response mux is a small always_comb inside this module.

Test Plan:
- Single D load:
  - Stimulus: dreq.valid=1, addr=32'h100, wen=0; mreq.ready=1 immediately; mresp.valid 2 cycles later with rdata=32'hDEADBEEF.
  - Required: dresp.valid one-cycle pulse with rdata=32'hDEADBEEF; iresp.valid stays 0; busy back to 0 the cycle after.
- Contention from reset (DATA_FIRST=1):
  - Stimulus: both requesters held valid for 4 transactions.
  - Required: mreq.addr order is D, I, D, I; each response goes only to its owner.
- Kill in flight:
  - Stimulus: I granted and accepted; i_kill=1 in WAIT_RESP; mresp.valid 3 cycles later.
  - Required: iresp.valid never asserted; the next I request is accepted normally.
- Valid withdrawn:
  - Stimulus: D granted, mreq.ready held 0 for 5 cycles, then dreq.valid drops.
  - Required: return to IDLE; mreq.valid deasserts; no response expected; a pending I request is then served.
- Error passthrough and local error:
  - Stimulus A: mresp.error=1, errty=FE_ACCESS_FAULT on a D store. Required: copied to dresp.
  - Stimulus B: ADDR_ALIGN_CHECK=1, D SIZE_W at addr 32'h102. Required: local error response, mreq.valid never asserted.
- Async reset mid-transaction:
  - Stimulus: assert reset in WAIT_RESP, not aligned to a clock edge.
  - Required: mreq.valid, dreq.ready and dresp.valid drop immediately; state=IDLE after release.
